// File: rtl/bus_master_if_pkg.sv
// ---------------------------------------------------------------------------
// bus_master_if_pkg
// Shared definitions for the bus master requester:
//   - FSM state encodings (BUS_MST_STATE_*) and the state bus width
//   - READ/WRITE direction encoding on bus_rw / core_rw
//   - ENABLE_N / DISABLE_N levels for the active-low bus strobes
// No ports; imported by the requester top.
// ---------------------------------------------------------------------------
package bus_master_if_pkg;

    localparam int BUS_MST_STATE_W = 2;

    // The fourth encoding is unused; the FSM treats it as a recovery state.
    typedef enum logic [BUS_MST_STATE_W-1:0] {
        BUS_MST_STATE_IDLE   = 2'd0,
        BUS_MST_STATE_REQ    = 2'd1,
        BUS_MST_STATE_ACCESS = 2'd2,
        BUS_MST_STATE_SPARE  = 2'd3
    } bus_mst_state_e;

    localparam logic BUS_READ  = 1'b1;

    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

endpackage

// File: rtl/bus_master_if_if.sv
// ---------------------------------------------------------------------------
// bus_master_if_if
// Shared system bus signals seen by one master slot.
//   master modport : drives bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data;
//                    receives bus_grnt_, bus_rd_data, bus_rdy_
//   slave modport  : the opposite side (arbiter + slave mux)
// All strobes ending in '_' are active-low.
// ---------------------------------------------------------------------------
interface bus_master_if_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    modport master (
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/bus_master_if_timer.sv
// ---------------------------------------------------------------------------
// bus_master_if_timer
// ACCESS-phase timeout counter, only instantiated when BUS_MASTER_TIMEOUT_EN
// is defined.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zero the count (ACCESS entry)
//   enable     : one ACCESS cycle elapsed without slave ready
//   expire     : this enabled cycle is number TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module bus_master_if_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    // The count only needs to reach TIMEOUT_CYCLES-1: the cycle that would
    // step it to TIMEOUT_CYCLES is the expiry cycle itself.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_d, count_q;

    assign expire = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expire) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if
// Master-side requester: turns one core word access into a shared-bus
// transaction (request -> grant -> address strobe -> slave ready) and
// returns read data with a one-cycle done pulse.
//   clk, reset    : clock, asynchronous active-low reset
//   core_req      : access request (sampled only while idle)
//   core_rw       : 1=READ, 0=WRITE
//   core_addr     : word address
//   core_wr_data  : write data
//   core_rd_data  : read data, valid with core_done
//   core_busy     : acceptance through the core_done cycle
//   core_done     : one-cycle completion pulse
//   core_err      : timeout flag, valid with core_done
//   bus           : bus_master_if_if.master (request/grant, strobes, data)
// Build option: define BUS_MASTER_TIMEOUT_EN to abort an ACCESS that sees no
// slave ready within TIMEOUT_CYCLES cycles (core_err=1, core_rd_data=0).
// Without it ACCESS waits forever and core_err is tied low.
// ---------------------------------------------------------------------------
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int          ADDR_W         = 30,
    parameter int          DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    bus_master_if_if.master   bus
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("bus_master_if: TIMEOUT_CYCLES must be at least 2");
    end

    bus_mst_state_e    state_d, state_q;
    logic              bus_req_n_d, bus_req_n_q;
    logic              bus_as_n_d, bus_as_n_q;
    logic              bus_rw_d, bus_rw_q;
    logic [ADDR_W-1:0] bus_addr_d, bus_addr_q;
    logic [DATA_W-1:0] bus_wr_data_d, bus_wr_data_q;
    logic [DATA_W-1:0] core_rd_data_d, core_rd_data_q;
    logic              core_busy_d, core_busy_q;
    logic              core_done_d, core_done_q;
    logic              timer_expire;

`ifdef BUS_MASTER_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;
    logic core_err_d, core_err_q;

    // Count restarts on the grant edge that enters ACCESS, and only advances
    // while the slave is still holding ready off.
    assign timer_clear  = (state_q == BUS_MST_STATE_REQ) && (bus.bus_grnt_ == ENABLE_N);
    assign timer_enable = (state_q == BUS_MST_STATE_ACCESS) && (bus.bus_rdy_ == DISABLE_N);

    bus_master_if_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    // Expire is already gated by "slave not ready", so a late ready wins.
    assign core_err_d = timer_expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_err_q <= 1'b0;
        end else begin
            core_err_q <= core_err_d;
        end
    end

    assign core_err = core_err_q;
`else
    assign timer_expire = 1'b0;
    assign core_err     = 1'b0;
`endif

    // Next-state and next-output logic. The request is released in the same
    // cycle core_done rises, and core_req is only looked at in IDLE, so the
    // bus always sees at least one cycle of bus_req_ high between accesses.
    always_comb begin
        state_d        = state_q;
        bus_req_n_d    = bus_req_n_q;
        bus_as_n_d     = bus_as_n_q;
        bus_rw_d       = bus_rw_q;
        bus_addr_d     = bus_addr_q;
        bus_wr_data_d  = bus_wr_data_q;
        core_rd_data_d = core_rd_data_q;
        core_busy_d    = core_busy_q;
        core_done_d    = 1'b0;

        case (state_q)
            BUS_MST_STATE_IDLE: begin
                // Grant is ignored here: the arbiter may park it on us.
                core_busy_d = 1'b0;
                if (core_req) begin
                    bus_rw_d      = core_rw;
                    bus_addr_d    = core_addr;
                    bus_wr_data_d = core_wr_data;
                    bus_req_n_d   = ENABLE_N;
                    core_busy_d   = 1'b1;
                    state_d       = BUS_MST_STATE_REQ;
                end
            end

            BUS_MST_STATE_REQ: begin
                if (bus.bus_grnt_ == ENABLE_N) begin
                    bus_as_n_d = ENABLE_N;
                    state_d    = BUS_MST_STATE_ACCESS;
                end
            end

            BUS_MST_STATE_ACCESS: begin
                if (bus.bus_rdy_ == ENABLE_N) begin
                    bus_as_n_d  = DISABLE_N;
                    bus_req_n_d = DISABLE_N;
                    core_done_d = 1'b1;
                    if (bus_rw_q == BUS_READ) begin
                        core_rd_data_d = bus.bus_rd_data;
                    end
                    state_d = BUS_MST_STATE_IDLE;
                end else if (timer_expire) begin
                    bus_as_n_d     = DISABLE_N;
                    bus_req_n_d    = DISABLE_N;
                    core_done_d    = 1'b1;
                    core_rd_data_d = '0;
                    state_d        = BUS_MST_STATE_IDLE;
                end
            end

            default: begin
                // Unused encoding: drop everything back to reset values.
                state_d        = BUS_MST_STATE_IDLE;
                bus_req_n_d    = DISABLE_N;
                bus_as_n_d     = DISABLE_N;
                bus_rw_d       = BUS_READ;
                bus_addr_d     = '0;
                bus_wr_data_d  = '0;
                core_rd_data_d = '0;
                core_busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= BUS_MST_STATE_IDLE;
            bus_req_n_q    <= DISABLE_N;
            bus_as_n_q     <= DISABLE_N;
            bus_rw_q       <= BUS_READ;
            bus_addr_q     <= '0;
            bus_wr_data_q  <= '0;
            core_rd_data_q <= '0;
            core_busy_q    <= 1'b0;
            core_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus_req_n_q    <= bus_req_n_d;
            bus_as_n_q     <= bus_as_n_d;
            bus_rw_q       <= bus_rw_d;
            bus_addr_q     <= bus_addr_d;
            bus_wr_data_q  <= bus_wr_data_d;
            core_rd_data_q <= core_rd_data_d;
            core_busy_q    <= core_busy_d;
            core_done_q    <= core_done_d;
        end
    end

    assign bus.bus_req_    = bus_req_n_q;
    assign bus.bus_as_     = bus_as_n_q;
    assign bus.bus_rw      = bus_rw_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wr_data = bus_wr_data_q;
    assign core_rd_data    = core_rd_data_q;
    assign core_busy       = core_busy_q;
    assign core_done       = core_done_q;
endmodule

// File: tb/tb_bus_master_if.sv
// ---------------------------------------------------------------------------
// tb_bus_master_if
// Directed bench for bus_master_if. Stimulus pushes the expected completion
// into a scoreboard queue; a negedge monitor pops and compares whenever the
// DUT pulses core_done. Timeout cases run only when BUS_MASTER_TIMEOUT_EN
// is defined (the DUT is built with TIMEOUT_CYCLES=8).
// ---------------------------------------------------------------------------
module tb_bus_master_if;
    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              core_req = 1'b0;
    logic              core_rw = 1'b1;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [DATA_W-1:0] core_wr_data = '0;
    logic [DATA_W-1:0] core_rd_data;
    logic              core_busy;
    logic              core_done;
    logic              core_err;

    // Bus-side stimulus: either directly driven, or from the tiny arbiter /
    // zero-wait slave models used by the back-to-back case.
    logic        drv_grnt_n = 1'b1;
    logic        drv_rdy_n = 1'b1;
    logic [31:0] drv_rd_data = '0;
    logic        arb_en = 1'b0;
    logic        slave_auto = 1'b0;
    logic        arb_grnt_n;
    int          owner_other = 0;
    int          other_cnt = 0;
    int          other_wins = 0;
    logic        other_pending = 1'b0;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    bus_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    assign arb_grnt_n       = (owner_other != 0);
    assign bus.bus_grnt_    = arb_en ? arb_grnt_n : drv_grnt_n;
    assign bus.bus_rdy_     = slave_auto ? bus.bus_as_ : drv_rdy_n;
    assign bus.bus_rd_data  = slave_auto ? (32'hC0DE_0000 | {16'h0, bus.bus_addr[15:0]}) : drv_rd_data;

    bus_master_if #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_rw      (core_rw),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_busy    (core_busy),
        .core_done    (core_done),
        .core_err     (core_err),
        .bus          (bus.master)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Competing master: once armed, it takes the bus the first negedge our
    // request is seen released, keeps it two cycles, then hands it back.
    always @(negedge clk) begin
        if (arb_en) begin
            if (owner_other == 0) begin
                if (bus.bus_req_ && other_pending) begin
                    owner_other = 1;
                    other_cnt = 2;
                    other_pending = 1'b0;
                    other_wins++;
                end
            end else begin
                other_cnt--;
                if (other_cnt == 0) owner_other = 0;
            end
        end
    end

    // Scoreboard monitor: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && core_done) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("rd_data", {32'h0, core_rd_data}, {32'h0, mon_e.rd});
                checkOutput("core_err", {63'h0, core_err}, {63'h0, mon_e.err});
                checkOutput("busy_at_done", {63'h0, core_busy}, 64'd1);
            end
        end
    end

    // Runs one access. Grant is pulled low once req_target REQ cycles have
    // been seen; ready is pulled low on ACCESS cycle as_target (0 = never).
    task automatic applyStimulus(
        input  logic              rw,
        input  logic [ADDR_W-1:0] addr,
        input  logic [DATA_W-1:0] wdata,
        input  logic [DATA_W-1:0] rdata,
        input  int                req_target,
        input  int                as_target,
        output int                req_cycles,
        output int                as_cycles,
        output int                first_as,
        output int                done_cycle,
        output int                unstable
    );
        core_rw      = rw;
        core_addr    = addr;
        core_wr_data = wdata;
        drv_rd_data  = rdata;
        drv_rdy_n    = 1'b1;
        core_req     = 1'b1;
        req_cycles   = 0;
        as_cycles    = 0;
        first_as     = -1;
        done_cycle   = -1;
        unstable     = 0;
        for (int cyc = 1; cyc <= 60 && done_cycle < 0; cyc++) begin
            tick();
            if (core_done) begin
                done_cycle = cyc;
                core_req   = 1'b0;
                drv_rdy_n  = 1'b1;
            end else begin
                if (!bus.bus_req_ && bus.bus_as_) begin
                    req_cycles++;
                    if (req_cycles >= req_target) drv_grnt_n = 1'b0;
                end
                if (!bus.bus_as_) begin
                    as_cycles++;
                    if (first_as < 0) first_as = cyc;
                    if (as_target > 0 && as_cycles >= as_target) drv_rdy_n = 1'b0;
                end
                if (bus.bus_addr !== addr || bus.bus_rw !== rw || bus.bus_wr_data !== wdata) unstable++;
            end
        end
        if (done_cycle < 0) begin
            checkOutput("done_wait_expired", 64'd0, 64'd1);
            core_req = 1'b0;
        end
    endtask

    initial begin
        int req_c, as_c, first_as, done_c, unst, cnt, dones, gap;

        // Reset state while reset is held low.
        #12;
        checkOutput("rst_bus_req_", {63'h0, bus.bus_req_}, 64'd1);
        checkOutput("rst_bus_as_", {63'h0, bus.bus_as_}, 64'd1);
        checkOutput("rst_bus_rw", {63'h0, bus.bus_rw}, 64'd1);
        checkOutput("rst_bus_addr", {34'h0, bus.bus_addr}, 64'd0);
        checkOutput("rst_bus_wr_data", {32'h0, bus.bus_wr_data}, 64'd0);
        checkOutput("rst_core_rd_data", {32'h0, core_rd_data}, 64'd0);
        checkOutput("rst_core_busy", {63'h0, core_busy}, 64'd0);
        checkOutput("rst_core_done", {63'h0, core_done}, 64'd0);
        checkOutput("rst_core_err", {63'h0, core_err}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Idle with a parked grant: no request, no strobe, no done.
        $display("[TB] idle with parked grant");
        drv_grnt_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!bus.bus_req_ || !bus.bus_as_ || core_busy) cnt++;
        end
        checkOutput("idle_activity", 64'(cnt), 64'd0);

        // Zero-wait READ with grant already present.
        $display("[TB] read, parked grant, zero-wait slave");
        sb_q.push_back('{rd: 32'hDEADBEEF, err: 1'b0});
        applyStimulus(1'b1, 30'h0000100, 32'h0, 32'hDEADBEEF, 1, 1, req_c, as_c, first_as, done_c, unst);
        checkOutput("rd_first_as_cycle", 64'(first_as), 64'd2);
        checkOutput("rd_as_cycles", 64'(as_c), 64'd1);
        checkOutput("rd_done_cycle", 64'(done_c), 64'd3);
        checkOutput("rd_bus_req_at_done", {63'h0, bus.bus_req_}, 64'd1);
        checkOutput("rd_stable", 64'(unst), 64'd0);
        tick();
        checkOutput("rd_busy_after_done", {63'h0, core_busy}, 64'd0);
        checkOutput("rd_done_pulse", {63'h0, core_done}, 64'd0);

        // WRITE with 4 REQ cycles and 2 slave wait states.
        $display("[TB] write, delayed grant, two wait states");
        drv_grnt_n = 1'b1;
        sb_q.push_back('{rd: 32'hDEADBEEF, err: 1'b0});
        applyStimulus(1'b0, 30'h0000200, 32'h12345678, 32'hBAD0BAD0, 4, 3, req_c, as_c, first_as, done_c, unst);
        checkOutput("wr_req_cycles", 64'(req_c), 64'd4);
        checkOutput("wr_as_cycles", 64'(as_c), 64'd3);
        checkOutput("wr_done_cycle", 64'(done_c), 64'd8);
        checkOutput("wr_stable", 64'(unst), 64'd0);
        tick();

        // Back-to-back READs with core_req held; a competitor takes the gap.
        $display("[TB] back-to-back reads with competing master");
        slave_auto    = 1'b1;
        owner_other   = 0;
        other_wins    = 0;
        other_pending = 1'b0;
        arb_en        = 1'b1;
        core_rw       = 1'b1;
        core_addr     = 30'h0000300;
        sb_q.push_back('{rd: 32'hC0DE0300, err: 1'b0});
        sb_q.push_back('{rd: 32'hC0DE0300, err: 1'b0});
        core_req = 1'b1;
        dones = 0;
        gap = 0;
        for (int cyc = 0; cyc < 60 && dones < 2; cyc++) begin
            tick();
            if (core_done) begin
                dones++;
                if (dones == 2) core_req = 1'b0;
            end
            if (dones == 0 && !bus.bus_as_) other_pending = 1'b1;
            if (dones == 1 && bus.bus_req_) gap++;
        end
        checkOutput("b2b_dones", 64'(dones), 64'd2);
        checkOutput("b2b_gap_ge1", 64'(gap >= 1), 64'd1);
        checkOutput("b2b_other_granted", 64'(other_wins), 64'd1);
        tick();
        arb_en     = 1'b0;
        slave_auto = 1'b0;
        drv_grnt_n = 1'b0;
        tick();

        // Reset asserted while in ACCESS: immediate reset values, no done.
        $display("[TB] reset during access");
        core_rw      = 1'b0;
        core_addr    = 30'h0000500;
        core_wr_data = 32'hCAFEF00D;
        drv_rdy_n    = 1'b1;
        core_req     = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("rst_mid_in_access", {63'h0, bus.bus_as_}, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        core_req = 1'b0;
        checkOutput("rst_mid_bus_req_", {63'h0, bus.bus_req_}, 64'd1);
        checkOutput("rst_mid_bus_as_", {63'h0, bus.bus_as_}, 64'd1);
        checkOutput("rst_mid_bus_rw", {63'h0, bus.bus_rw}, 64'd1);
        checkOutput("rst_mid_bus_addr", {34'h0, bus.bus_addr}, 64'd0);
        checkOutput("rst_mid_bus_wr_data", {32'h0, bus.bus_wr_data}, 64'd0);
        checkOutput("rst_mid_core_rd_data", {32'h0, core_rd_data}, 64'd0);
        checkOutput("rst_mid_core_busy", {63'h0, core_busy}, 64'd0);
        checkOutput("rst_mid_core_done", {63'h0, core_done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (core_busy || !bus.bus_as_ || !bus.bus_req_) cnt++;
        end
        checkOutput("post_reset_quiet", 64'(cnt), 64'd0);

`ifdef BUS_MASTER_TIMEOUT_EN
        // Slave never ready: abort after TIMEOUT ACCESS cycles.
        $display("[TB] timeout, slave never ready");
        sb_q.push_back('{rd: 32'h0, err: 1'b1});
        applyStimulus(1'b1, 30'h0000400, 32'h0, 32'h11111111, 1, 0, req_c, as_c, first_as, done_c, unst);
        checkOutput("to_as_cycles", 64'(as_c), 64'd8);
        checkOutput("to_done_cycle", 64'(done_c), 64'd10);
        checkOutput("to_bus_req_released", {63'h0, bus.bus_req_}, 64'd1);
        checkOutput("to_bus_as_released", {63'h0, bus.bus_as_}, 64'd1);
        tick();
        checkOutput("to_err_clears", {63'h0, core_err}, 64'd0);

        // Ready arrives in the expiry cycle: normal completion wins.
        $display("[TB] ready in expiry cycle");
        sb_q.push_back('{rd: 32'h600DF00D, err: 1'b0});
        applyStimulus(1'b1, 30'h0000400, 32'h0, 32'h600DF00D, 1, 8, req_c, as_c, first_as, done_c, unst);
        checkOutput("late_rdy_as_cycles", 64'(as_c), 64'd8);
        checkOutput("late_rdy_done_cycle", 64'(done_c), 64'd10);
        tick();
`endif

        tick();
        tick();
        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
Master-side requester for the shared system bus. It takes a single word access from a local core port and asserts the active-low bus request to the bus arbiter. It waits for that master slot's grant, drives address/strobe/direction/write data, and waits for the slave-side ready. It then returns read data to the core and releases the bus. One instance per bus master slot (0..3); the mN_req_ / mN_grnt_ pair of that slot connects to bus_req_ / bus_grnt_.

Parameters:
ADDR_W, 30, word-address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, ACCESS cycles before abort (only with BUS_MASTER_TIMEOUT_EN); minimum 2

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-low
core_req  in  1  access request, active-high; sampled only in IDLE
core_rw  in  1  1=READ, 0=WRITE
core_addr  in  ADDR_W  word address
core_wr_data  in  DATA_W  write data
core_rd_data  out  DATA_W  read data; valid with core_done
core_busy  out  1  high from acceptance until the core_done cycle inclusive
core_done  out  1  one-cycle completion pulse
core_err  out  1  timeout flag, valid with core_done; constant 0 without macro
bus_req_  out  1  bus request to arbiter, active-low
bus_grnt_  in  1  bus grant from arbiter, active-low
bus_addr  out  ADDR_W  bus address
bus_as_  out  1  address strobe, active-low
bus_rw  out  1  1=READ, 0=WRITE
bus_wr_data  out  DATA_W  bus write data
bus_rd_data  in  DATA_W  read data from slave mux
bus_rdy_  in  1  slave ready, active-low

Behaviour:
- All outputs are registered.
- Reset values (asynchronous):
  - state=IDLE
  - bus_req_=1, bus_as_=1, bus_rw=1 (READ), bus_addr=0, bus_wr_data=0
  - core_rd_data=0, core_busy=0, core_done=0, core_err=0
- Reset mid-transaction: outputs return immediately to reset values; the transaction is discarded with no core_done.
- IDLE:
  - core_req=1 → latch core_rw, core_addr and core_wr_data into bus_rw, bus_addr and bus_wr_data.
  - In the same transition: bus_req_←0, core_busy←1, go REQ.
  - bus_grnt_ is ignored in IDLE. The arbiter parks its grant on the last owner (master 0 after reset), so a grant can be present with no request.
- REQ:
  - bus_req_ held 0; bus_as_ stays 1.
  - bus_grnt_=0 → bus_as_←0, go ACCESS.
  - No limit on waiting for the grant; bus_addr, bus_rw and bus_wr_data stay stable.
- ACCESS:
  - bus_as_ stays 0 until bus_rdy_=0 is sampled.
  - On bus_rdy_=0:
    - bus_as_←1, bus_req_←1, core_done←1, go IDLE.
    - READ: core_rd_data←bus_rd_data. WRITE: core_rd_data unchanged.
  - bus_grnt_ is ignored after ACCESS is entered; the arbiter holds the grant while the request is asserted.
- core_done cycle: core_busy=1 in this cycle, 0 on the next.
- Minimum latency with a parked grant and zero-wait slave:
  - cycle 0 core_req → cycle 1 REQ → cycle 2 ACCESS with as_=0 and rdy_=0 → cycle 3 core_done.
  - Each slave wait state adds one cycle; each arbitration wait adds one cycle.
- Fairness between transactions:
  - bus_req_ is deasserted for at least one cycle after every transaction, because core_req is sampled only in IDLE.
  - Back-to-back accesses therefore re-arbitrate, so round-robin peers can win.
- core_req high in a non-IDLE state is ignored; the core holds the request until core_done.
- State encoding: 2 bits — IDLE, REQ, ACCESS, plus one spare encoding that recovers to IDLE with reset output values.

Optional Feature:
BUS_MASTER_TIMEOUT_EN
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle with bus_rdy_=1.
  - When it reaches TIMEOUT_CYCLES with bus_rdy_ still 1: bus_as_←1, bus_req_←1, core_done←1, core_err←1, core_rd_data←0, go IDLE.
  - core_err clears on the next cycle.
  - bus_rdy_=0 in the expiry cycle takes priority: normal completion with core_err=0.
- Undefined: ACCESS waits indefinitely; core_err is tied 0 and no counter is present.

Decomposition:
- bus.h: add the state encodings (BUS_MST_STATE_IDLE, _REQ, _ACCESS) and the state bus width.
- Existing shared definitions (global headers, reused as-is): READ/WRITE encodings, word address/data widths, ENABLE_/DISABLE_, RESET_EDGE/RESET_ENABLE, extended for active-low reset.
- Sub-module bus_master_timer: the timeout counter with clear/enable/expire. Instantiated only under BUS_MASTER_TIMEOUT_EN.

Test Plan:
- Reset released, grant parked at master 0, idle core → bus_req_=1 and bus_as_=1 held. No core_done, even with bus_grnt_=0.
- READ to addr 0x0000100, bus_grnt_ already 0, slave returns rdy_=0 with data 0xDEADBEEF in the first ACCESS cycle:
  - bus_as_=0 in cycle 2 only.
  - core_done with core_rd_data=0xDEADBEEF in cycle 3; bus_req_=1 in cycle 3.
- WRITE 0x12345678 to 0x0000200 with grant delayed 4 cycles and 2 slave wait states:
  - bus_req_ low for 4 REQ cycles; as_ low 3 cycles.
  - bus_wr_data, bus_addr and bus_rw stable throughout; core_done once; core_rd_data unchanged.
- Core_req held high through 2 back-to-back READs → bus_req_ high for ≥1 cycle between them. A competing arbiter requester sees its grant in the gap.
- reset driven low in ACCESS → all outputs at reset values immediately; no core_done after reset release.
- With BUS_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never ready:
  - core_done=1, core_err=1, core_rd_data=0 after 8 ACCESS cycles; bus_as_ and bus_req_ released.
  - Repeat with rdy_=0 at cycle 8 → core_err=0.
